// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, occupancy and flag sequencer for a one-access-per-cycle
// FIFO memory. It arbitrates push/pop requesters so that at most one memory strobe is high.
// Ports:
//   clk, rst                  clock, async active-high reset
//   push_req/push_data        push requester in
//   push_ack                  push grant, combinational
//   pop_req                   pop requester in
//   pop_ack                   pop grant, combinational
//   pop_valid, pop_data       registered read result
//   count/full/empty/almost_full  registered occupancy and flags
//   mem_wr_fifo, mem_rd_fifo  memory strobes, never both high
//   mem_wr_addr, mem_rd_addr  memory addresses
//   mem_wr_data, mem_rd_data  memory data paths
module fifo_ctrl #(
  parameter int DATA_SIZE  = 16,
  parameter int ADDR_DEPTH = 16,
  parameter int AF_LEVEL   = 12
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            push_req,
  input  logic [DATA_SIZE-1:0]            push_data,
  output logic                            push_ack,
  input  logic                            pop_req,
  output logic                            pop_ack,
  output logic                            pop_valid,
  output logic [DATA_SIZE-1:0]            pop_data,
  output logic [$clog2(ADDR_DEPTH+1)-1:0] count,
  output logic                            full,
  output logic                            empty,
  output logic                            almost_full,
  output logic                            mem_wr_fifo,
  output logic                            mem_rd_fifo,
  output logic [ADDR_DEPTH-1:0]           mem_wr_addr,
  output logic [ADDR_DEPTH-1:0]           mem_rd_addr,
  output logic [DATA_SIZE-1:0]            mem_wr_data,
  input  logic [DATA_SIZE-1:0]            mem_rd_data
);

  localparam int CNT_W = $clog2(ADDR_DEPTH+1);
  localparam int PTR_W = $clog2(ADDR_DEPTH);

  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(ADDR_DEPTH-1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(ADDR_DEPTH);
  localparam logic [CNT_W-1:0] CNT_AF   = CNT_W'(AF_LEVEL);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full_q, empty_q, af_q;
  logic             pop_valid_q;
  logic             prio_pop_q;

  logic push_ok, pop_ok, contest;
  logic gnt_push, gnt_pop;

  assign push_ok = push_req & ~full_q;
  assign pop_ok  = pop_req & ~empty_q;
  assign contest = push_ok & pop_ok;

  // On a contest the side holding priority wins.
  assign gnt_pop  = pop_ok & (~push_ok | prio_pop_q);
  assign gnt_push = push_ok & (~pop_ok | ~prio_pop_q);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (gnt_push) begin
      wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
      count_d  = count_q + 1'b1;
    end
    if (gnt_pop) begin
      rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      af_q        <= 1'b0;
      pop_valid_q <= 1'b0;
      prio_pop_q  <= 1'b1;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      full_q      <= (count_d == CNT_FULL);
      empty_q     <= (count_d == '0);
      af_q        <= (count_d >= CNT_AF);
      pop_valid_q <= gnt_pop;
      if (contest)
        prio_pop_q <= ~prio_pop_q;
    end
  end

  assign push_ack    = gnt_push;
  assign pop_ack     = gnt_pop;
  assign mem_wr_fifo = gnt_push;
  assign mem_rd_fifo = gnt_pop;
  assign mem_wr_addr = ADDR_DEPTH'(wr_ptr_q);
  assign mem_rd_addr = ADDR_DEPTH'(rd_ptr_q);
  assign mem_wr_data = push_data;
  assign pop_data    = mem_rd_data;
  assign pop_valid   = pop_valid_q;
  assign count       = count_q;
  assign full        = full_q;
  assign empty       = empty_q;
  assign almost_full = af_q;

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: scoreboard bench for fifo_ctrl with behavioural memories.
// Instance A is 16 deep, instance B is 12 deep for pointer wrap.
module tb_fifo_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic        a_push_req = 1'b0;
  logic [15:0] a_push_data = '0;
  logic        a_push_ack;
  logic        a_pop_req = 1'b0;
  logic        a_pop_ack;
  logic        a_pop_valid;
  logic [15:0] a_pop_data;
  logic [4:0]  a_count;
  logic        a_full, a_empty, a_af;
  logic        a_wr, a_rd;
  logic [15:0] a_wa, a_ra;
  logic [15:0] a_wd;
  logic [15:0] a_rdd = '0;
  logic [15:0] mem_a [16];

  fifo_ctrl #(.DATA_SIZE(16), .ADDR_DEPTH(16), .AF_LEVEL(12)) u_a (
    .clk(clk), .rst(rst),
    .push_req(a_push_req), .push_data(a_push_data), .push_ack(a_push_ack),
    .pop_req(a_pop_req), .pop_ack(a_pop_ack),
    .pop_valid(a_pop_valid), .pop_data(a_pop_data),
    .count(a_count), .full(a_full), .empty(a_empty),
    .almost_full(a_af),
    .mem_wr_fifo(a_wr), .mem_rd_fifo(a_rd),
    .mem_wr_addr(a_wa), .mem_rd_addr(a_ra),
    .mem_wr_data(a_wd), .mem_rd_data(a_rdd)
  );

  // Memory ignores both strobes when they collide.
  always @(posedge clk) begin
    if (a_wr && !a_rd) mem_a[a_wa[3:0]] <= a_wd;
    if (a_rd && !a_wr) a_rdd <= mem_a[a_ra[3:0]];
  end

  logic        b_push_req = 1'b0;
  logic [15:0] b_push_data = '0;
  logic        b_push_ack;
  logic        b_pop_req = 1'b0;
  logic        b_pop_ack;
  logic        b_pop_valid;
  logic [15:0] b_pop_data;
  logic [3:0]  b_count;
  logic        b_full, b_empty, b_af;
  logic        b_wr, b_rd;
  logic [11:0] b_wa, b_ra;
  logic [15:0] b_wd;
  logic [15:0] b_rdd = '0;
  logic [15:0] mem_b [16];

  fifo_ctrl #(.DATA_SIZE(16), .ADDR_DEPTH(12), .AF_LEVEL(10)) u_b (
    .clk(clk), .rst(rst),
    .push_req(b_push_req), .push_data(b_push_data), .push_ack(b_push_ack),
    .pop_req(b_pop_req), .pop_ack(b_pop_ack),
    .pop_valid(b_pop_valid), .pop_data(b_pop_data),
    .count(b_count), .full(b_full), .empty(b_empty),
    .almost_full(b_af),
    .mem_wr_fifo(b_wr), .mem_rd_fifo(b_rd),
    .mem_wr_addr(b_wa), .mem_rd_addr(b_ra),
    .mem_wr_data(b_wd), .mem_rd_data(b_rdd)
  );

  always @(posedge clk) begin
    if (b_wr && !b_rd) mem_b[b_wa[3:0]] <= b_wd;
    if (b_rd && !b_wr) b_rdd <= mem_b[b_ra[3:0]];
  end

  // Reference model for instance A.
  logic [15:0] m_q [$];
  logic [15:0] exp_q [$];
  logic        m_prio;
  logic        e_push, e_pop;
  logic        o_push, o_pop, o_wr, o_rd;
  logic [15:0] o_wa, o_ra;
  logic [15:0] exp_d;

  task automatic model_reset;
    m_q.delete();
    exp_q.delete();
    m_prio = 1'b1;
  endtask

  task automatic cyc_a(input logic ps, input logic [15:0] pd, input logic pp);
    @(negedge clk);
    a_push_req  = ps;
    a_push_data = pd;
    a_pop_req   = pp;
    e_push = ps && (m_q.size() < 16);
    e_pop  = pp && (m_q.size() > 0);
    if (e_push && e_pop) begin
      if (m_prio) e_push = 1'b0;
      else        e_pop  = 1'b0;
      m_prio = ~m_prio;
    end
    #1;
    o_push = a_push_ack;
    o_pop  = a_pop_ack;
    o_wr   = a_wr;
    o_rd   = a_rd;
    o_wa   = a_wa;
    o_ra   = a_ra;
    if (e_pop)  exp_q.push_back(m_q.pop_front());
    if (e_push) m_q.push_back(pd);
    @(posedge clk);
    #1;
    a_push_req = 1'b0;
    a_pop_req  = 1'b0;
  endtask

  task automatic test_reset;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL rst_empty got %b want 1", a_empty); end
    n_vec++; if (a_full !== 1'b0) begin n_err++; $display("FAIL rst_full got %b want 0", a_full); end
    n_vec++; if (a_count !== 5'd0) begin n_err++; $display("FAIL rst_count got %0d want 0", a_count); end
    n_vec++; if (a_pop_valid !== 1'b0) begin n_err++; $display("FAIL rst_pop_valid got %b want 0", a_pop_valid); end
    n_vec++; if (a_af !== 1'b0) begin n_err++; $display("FAIL rst_af got %b want 0", a_af); end
    n_vec++; if ({a_wr, a_rd} !== 2'b00) begin n_err++; $display("FAIL rst_strobes got %b want 00", {a_wr, a_rd}); end
    n_vec++; if (b_empty !== 1'b1) begin n_err++; $display("FAIL rst_b_empty got %b want 1", b_empty); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_fill;
    for (int i = 0; i < 16; i++) begin
      cyc_a(1'b1, 16'h1000 + 16'(i), 1'b0);
      n_vec++; if (o_push !== 1'b1 || o_wr !== 1'b1) begin n_err++; $display("FAIL fill_ack[%0d] got %b%b want 11", i, o_push, o_wr); end
      n_vec++; if (o_wa !== 16'(i)) begin n_err++; $display("FAIL fill_addr[%0d] got %0d want %0d", i, o_wa, i); end
      n_vec++; if (a_count !== 5'(i + 1)) begin n_err++; $display("FAIL fill_count[%0d] got %0d want %0d", i, a_count, i + 1); end
      n_vec++; if (a_af !== (i + 1 >= 12)) begin n_err++; $display("FAIL fill_af[%0d] got %b want %b", i, a_af, (i + 1 >= 12)); end
      n_vec++; if (a_full !== (i == 15)) begin n_err++; $display("FAIL fill_full[%0d] got %b want %b", i, a_full, (i == 15)); end
    end
    cyc_a(1'b1, 16'hDEAD, 1'b0);
    n_vec++; if (o_push !== 1'b0 || o_wr !== 1'b0) begin n_err++; $display("FAIL fill_over_ack got %b%b want 00", o_push, o_wr); end
    n_vec++; if (a_count !== 5'd16) begin n_err++; $display("FAIL fill_over_count got %0d want 16", a_count); end
    n_vec++; if (mem_a[0] !== 16'h1000) begin n_err++; $display("FAIL fill_over_mem0 got %h want 1000", mem_a[0]); end
  endtask

  task automatic test_drain;
    for (int i = 0; i < 16; i++) begin
      cyc_a(1'b0, 16'h0, 1'b1);
      n_vec++; if (o_pop !== 1'b1 || o_rd !== 1'b1) begin n_err++; $display("FAIL drain_ack[%0d] got %b%b want 11", i, o_pop, o_rd); end
      n_vec++; if (o_ra !== 16'(i)) begin n_err++; $display("FAIL drain_addr[%0d] got %0d want %0d", i, o_ra, i); end
      n_vec++; if (a_pop_valid !== e_pop) begin n_err++; $display("FAIL drain_valid[%0d] got %b want %b", i, a_pop_valid, e_pop); end
      if (e_pop) begin
        exp_d = exp_q.pop_front();
        n_vec++; if (a_pop_data !== exp_d) begin n_err++; $display("FAIL drain_data[%0d] got %h want %h", i, a_pop_data, exp_d); end
      end
      n_vec++; if (a_count !== 5'(15 - i)) begin n_err++; $display("FAIL drain_count[%0d] got %0d want %0d", i, a_count, 15 - i); end
      n_vec++; if (a_empty !== (i == 15)) begin n_err++; $display("FAIL drain_empty[%0d] got %b want %b", i, a_empty, (i == 15)); end
    end
    cyc_a(1'b0, 16'h0, 1'b1);
    n_vec++; if (o_pop !== 1'b0 || o_rd !== 1'b0) begin n_err++; $display("FAIL drain_under_ack got %b%b want 00", o_pop, o_rd); end
    n_vec++; if (a_pop_valid !== 1'b0) begin n_err++; $display("FAIL drain_under_valid got %b want 0", a_pop_valid); end
  endtask

  task automatic test_contest;
    for (int i = 0; i < 4; i++) cyc_a(1'b1, 16'h3000 + 16'(i), 1'b0);
    n_vec++; if (a_count !== 5'd4) begin n_err++; $display("FAIL contest_pre_count got %0d want 4", a_count); end
    for (int i = 0; i < 8; i++) begin
      cyc_a(1'b1, 16'h3100 + 16'(i), 1'b1);
      n_vec++; if (o_pop !== (i % 2 == 0) || o_push !== (i % 2 == 1)) begin n_err++; $display("FAIL contest_grant[%0d] got push=%b pop=%b want pop=%b", i, o_push, o_pop, (i % 2 == 0)); end
      n_vec++; if (o_wr && o_rd) begin n_err++; $display("FAIL contest_both_strobes[%0d] got 11 want one-hot", i); end
      n_vec++; if (a_count !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin n_err++; $display("FAIL contest_count[%0d] got %0d want %0d", i, a_count, (i % 2 == 0) ? 3 : 4); end
      n_vec++; if (a_pop_valid !== e_pop) begin n_err++; $display("FAIL contest_valid[%0d] got %b want %b", i, a_pop_valid, e_pop); end
      if (e_pop) begin
        exp_d = exp_q.pop_front();
        n_vec++; if (a_pop_data !== exp_d) begin n_err++; $display("FAIL contest_data[%0d] got %h want %h", i, a_pop_data, exp_d); end
      end
    end
    for (int i = 0; i < 4; i++) begin
      cyc_a(1'b0, 16'h0, 1'b1);
      n_vec++; if (a_pop_valid !== e_pop) begin n_err++; $display("FAIL contest_tail_valid[%0d] got %b want %b", i, a_pop_valid, e_pop); end
      if (e_pop) begin
        exp_d = exp_q.pop_front();
        n_vec++; if (a_pop_data !== exp_d) begin n_err++; $display("FAIL contest_tail_data[%0d] got %h want %h", i, a_pop_data, exp_d); end
      end
    end
    n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL contest_end_empty got %b want 1", a_empty); end
  endtask

  task automatic test_wrap;
    logic [15:0] bq [$];
    logic [15:0] bexp [$];
    logic [15:0] bd;
    int wp = 0;
    int rp = 0;
    logic ps, pp, ep, eq;
    for (int i = 0; i < 40; i++) begin
      ps = (i < 30) && (i % 3 != 2);
      pp = (i >= 30) || (i % 3 == 2);
      @(negedge clk);
      b_push_req  = ps;
      b_push_data = 16'h2000 + 16'(i);
      b_pop_req   = pp;
      ep = ps && (bq.size() < 12);
      eq = pp && (bq.size() > 0);
      #1;
      n_vec++; if (b_push_ack !== ep || b_pop_ack !== eq) begin n_err++; $display("FAIL wrap_ack[%0d] got %b%b want %b%b", i, b_push_ack, b_pop_ack, ep, eq); end
      n_vec++; if (b_wa >= 12 || b_ra >= 12) begin n_err++; $display("FAIL wrap_range[%0d] got wa=%0d ra=%0d want <12", i, b_wa, b_ra); end
      if (ep) begin
        n_vec++; if (b_wa !== 12'(wp)) begin n_err++; $display("FAIL wrap_wa[%0d] got %0d want %0d", i, b_wa, wp); end
        bq.push_back(16'h2000 + 16'(i));
        wp = (wp == 11) ? 0 : wp + 1;
      end
      if (eq) begin
        n_vec++; if (b_ra !== 12'(rp)) begin n_err++; $display("FAIL wrap_ra[%0d] got %0d want %0d", i, b_ra, rp); end
        bexp.push_back(bq.pop_front());
        rp = (rp == 11) ? 0 : rp + 1;
      end
      @(posedge clk);
      #1;
      b_push_req = 1'b0;
      b_pop_req  = 1'b0;
      n_vec++; if (b_pop_valid !== eq) begin n_err++; $display("FAIL wrap_valid[%0d] got %b want %b", i, b_pop_valid, eq); end
      if (eq) begin
        bd = bexp.pop_front();
        n_vec++; if (b_pop_data !== bd) begin n_err++; $display("FAIL wrap_data[%0d] got %h want %h", i, b_pop_data, bd); end
      end
    end
    n_vec++; if (b_empty !== 1'b1 || b_count !== 4'd0) begin n_err++; $display("FAIL wrap_end got empty=%b count=%0d want 1/0", b_empty, b_count); end
  endtask

  task automatic test_reset_midstream;
    for (int i = 0; i < 3; i++) cyc_a(1'b1, 16'h4000 + 16'(i), 1'b0);
    cyc_a(1'b0, 16'h0, 1'b1);
    n_vec++; if (a_pop_valid !== 1'b1) begin n_err++; $display("FAIL mid_pre_valid got %b want 1", a_pop_valid); end
    if (e_pop) exp_d = exp_q.pop_front();
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    n_vec++; if (a_pop_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid got %b want 0", a_pop_valid); end
    n_vec++; if (a_count !== 5'd0) begin n_err++; $display("FAIL mid_count got %0d want 0", a_count); end
    n_vec++; if (a_empty !== 1'b1) begin n_err++; $display("FAIL mid_empty got %b want 1", a_empty); end
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    cyc_a(1'b1, 16'hBEEF, 1'b0);
    n_vec++; if (o_push !== 1'b1 || o_wa !== 16'd0) begin n_err++; $display("FAIL mid_first_push got ack=%b addr=%0d want 1/0", o_push, o_wa); end
    cyc_a(1'b0, 16'h0, 1'b1);
    n_vec++; if (o_ra !== 16'd0) begin n_err++; $display("FAIL mid_first_pop_addr got %0d want 0", o_ra); end
    if (e_pop) begin
      exp_d = exp_q.pop_front();
      n_vec++; if (a_pop_data !== exp_d || a_pop_valid !== 1'b1) begin n_err++; $display("FAIL mid_first_pop got %h/%b want %h/1", a_pop_data, a_pop_valid, exp_d); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fill();
    test_drain();
    test_contest();
    test_wrap();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_ctrl.md
# fifo_ctrl

Sequencing controller for the team's single-port-per-cycle FIFO memory block (one write *or* one read per clock, registered read data). It owns the write/read pointers, occupancy count and full/empty flags. It arbitrates between a push requester and a pop requester, and drives the memory's write/read strobes, addresses and write data. It guarantees the memory never receives write and read strobes in the same cycle, because the memory ignores both in that case.

## Interface
- DATA_SIZE, 16, width of a FIFO word.
- ADDR_DEPTH, 16, number of memory entries.
  - Also the width of the memory address buses.
  - Need not be a power of two; must be at least 2.
- AF_LEVEL, 12, almost_full threshold; 1 ≤ AF_LEVEL ≤ ADDR_DEPTH.
- CNT_W (derived), $clog2(ADDR_DEPTH+1).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- push_req  in  1  requester wants to write push_data this cycle.
- push_data  in  DATA_SIZE  word to push.
- push_ack  out  1  combinational; push accepted this cycle.
- pop_req  in  1  requester wants one word this cycle.
- pop_ack  out  1  combinational; pop accepted this cycle.
- pop_valid  out  1  registered; pop_data valid (one cycle after pop_ack).
- pop_data  out  DATA_SIZE  pass-through of mem_rd_data.
- count  out  CNT_W  registered occupancy, 0..ADDR_DEPTH.
- full  out  1  registered; count == ADDR_DEPTH.
- empty  out  1  registered; count == 0.
- almost_full  out  1  registered; count ≥ AF_LEVEL.
- mem_wr_fifo  out  1  memory write strobe.
- mem_rd_fifo  out  1  memory read strobe.
- mem_wr_addr  out  ADDR_DEPTH  write pointer, zero-extended.
- mem_rd_addr  out  ADDR_DEPTH  read pointer, zero-extended.
- mem_wr_data  out  DATA_SIZE  equals push_data.
- mem_rd_data  in  DATA_SIZE  registered read data from memory.

## Operation
Eligibility:
- push_ok = push_req & !full.
- pop_ok = pop_req & !empty.

Arbitration (combinational; prio_pop is a 1-bit register):
- Only push_ok: grant push.
- Only pop_ok: grant pop.
- Both (contest): grant pop if prio_pop, else grant push. On the contest edge, prio_pop flips so the winner is lowest priority next contest.
- Uncontested grants leave prio_pop unchanged.
- Neither: no grant; all strobes low.

Strobe and handshake mapping:
- mem_wr_fifo = push_ack = push grant.
- mem_rd_fifo = pop_ack = pop grant.
- At most one of these is ever high.

Pointer updates:
- wr_ptr advances on a push grant; rd_ptr advances on a pop grant.
- Each wraps ADDR_DEPTH-1 → 0. Do not use modulo-2^n wrap.

Count and flags:
- count: +1 on push grant, −1 on pop grant. Never both, so never stalls.
- full, empty and almost_full are registered from next-count, so they are consistent with count every cycle.

Read pipeline:
- pop_valid <= pop_ack.
- pop_data is mem_rd_data, valid while pop_valid = 1.
- Memory holds rd_data between reads.

Error behaviour:
- Push while full: stalls (no ack); data is not written.
- Pop while empty: stalls; pop_valid stays 0.

## Timing
Reset (async, immediate, no clock needed):
- wr_ptr = rd_ptr = 0, count = 0.
- empty = 1, full = 0, almost_full = 0, pop_valid = 0.
- prio_pop = 1 (first contest goes to pop).
- Memory contents are not cleared. A read in flight is discarded.

Latency:
- Push: ack in the request cycle; the word is written at that edge.
- Pop: ack in the request cycle; data plus pop_valid on the next cycle.
- Push to poppable: 1 cycle. Flags update at the push edge, so pop may be requested the next cycle and reads the just-written entry.

Throughput:
- Sustained push+pop contest gives 1 word/2 cycles each, strictly alternating.

Boundaries:
- count = ADDR_DEPTH−1 with push and pop contest: either winner is legal. Push makes full = 1 the next cycle.
- count = 1 with contest: pop winning makes empty = 1 the next cycle.
- Deassertion of rst is assumed synchronous to clk (externally synchronised).

## Test plan
- **Reset:** assert rst mid-cycle with no clock edge.
  - Immediately: empty = 1, full = 0, count = 0, pop_valid = 0.
  - mem_wr_fifo = mem_rd_fifo = 0.
- **Fill:** 16 consecutive pushes of 0x1000..0x100F.
  - mem_wr_addr = 0..15; count reaches 16; full = 1 after the 16th edge.
  - almost_full rises after the 12th push.
  - A 17th push_req gets push_ack = 0 and no write.
- **Drain:** 16 pops after the fill.
  - pop_data = 0x1000..0x100F in order, each with pop_valid the cycle after pop_ack.
  - empty = 1 after the 16th; a further pop_req gets no ack.
- **Contest:** count = 4, push_req and pop_req held for 8 cycles.
  - Grants are pop, push, pop, push, …
  - Never both strobes high; count oscillates 3/4.
- **Wrap (ADDR_DEPTH = 12):** 30 interleaved pushes/pops.
  - Pointers go 11 → 0.
  - Output order equals input order; no value ≥ 12 appears on either address bus.
- **Reset mid-stream:** assert rst the cycle after a pop_ack.
  - pop_valid = 0 immediately; count = 0.
  - After release, the first push writes address 0.
